// File: rtl/mips_decode_alu_pkg.sv
// mips_pkg: shared constants and types for the ID/EX decode + ALU slice.
//   - opcode / funct field encodings
//   - ALUOp (main decoder -> ALU-control decoder) and ALU operation codes
//   - bit positions of the registered control bundle ctrl_q
// Optional feature macro used by the files importing this package:
//   ALU_OVERFLOW_DET_EN (adds the registered signed-overflow flag ovf_q).
package mips_pkg;

    // Opcode field instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // Funct field instr[5:0] for R-type
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluOp_e;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SLL     = 4'b0011,
        ALU_SRL     = 4'b0100,
        ALU_XOR     = 4'b0101,
        ALU_SUB     = 4'b0110,
        ALU_SLT     = 4'b0111,
        ALU_NOR     = 4'b1100,
        ALU_SRA     = 4'b1101,
        ALU_INVALID = 4'b1111
    } aluCtl_e;

    // ctrl_q = {reg_write, mem_to_reg, branch, mem_read, mem_write}
    localparam int unsigned CTRL_W         = 5;
    localparam int unsigned CB_REG_WRITE   = 4;
    localparam int unsigned CB_MEM_TO_REG  = 3;
    localparam int unsigned CB_BRANCH      = 2;
    localparam int unsigned CB_MEM_READ    = 1;
    localparam int unsigned CB_MEM_WRITE   = 0;

endpackage

// File: rtl/mips_decode_alu_if.sv
// mips_decode_alu_if: bundles the instruction fields, operands, decoded
// controls and registered EX/MEM outputs of mips_decode_alu.
//   master: drives hold/opcode/funct/shamt/rs_val/rt_val/imm_ext, observes the rest
//   slave : the decode/ALU block (inverse directions)
// ALU_OVERFLOW_DET_EN adds ovf_q.
interface mips_decode_alu_if #(parameter int DATA_W = 32);
    import mips_pkg::*;

    logic              hold;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;

    logic              reg_dst;
    logic              branch;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic [1:0]        alu_op;
    logic [3:0]        alu_ctl;

    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic [CTRL_W-1:0] ctrl_q;
`ifdef ALU_OVERFLOW_DET_EN
    logic              ovf_q;
`endif

    modport master (
        output hold, opcode, funct, shamt, rs_val, rt_val, imm_ext,
        input  reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
        input  alu_op, alu_ctl, res_q, zero_q, ctrl_q
`ifdef ALU_OVERFLOW_DET_EN
        , input ovf_q
`endif
    );

    modport slave (
        input  hold, opcode, funct, shamt, rs_val, rt_val, imm_ext,
        output reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
        output alu_op, alu_ctl, res_q, zero_q, ctrl_q
`ifdef ALU_OVERFLOW_DET_EN
        , output ovf_q
`endif
    );

endinterface

// File: rtl/mips_decode_alu_core.sv
// mips_alu_core: purely combinational 32-bit ALU.
//   a, b   : operands (b already muxed between rt and immediate)
//   shamt  : shift amount applied to b for SLL/SRL/SRA
//   ctl    : 4-bit ALU operation code (undefined codes give result 0)
//   result : operation result, zero : result == 0
//   ovf    : signed overflow of ADD/SUB (only with ALU_OVERFLOW_DET_EN)
module mips_alu_core
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  logic [3:0]        ctl,
    output logic [DATA_W-1:0] result,
    output logic              zero
`ifdef ALU_OVERFLOW_DET_EN
    ,
    output logic              ovf
`endif
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              lessThan;

    assign sum      = a + b;
    assign diff     = a - b;
    assign lessThan = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, lessThan};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_SRA: result = $signed(b) >>> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

`ifdef ALU_OVERFLOW_DET_EN
    always_comb begin
        ovf = 1'b0;
        case (ctl)
            ALU_ADD: ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            ALU_SUB: ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/mips_decode_alu.sv
// mips_decode_alu: main-control decoder, ALU-control decoder and ALU at the
// ID/EX boundary of the 5-stage MIPS core.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset of the output registers
//   bus  : mips_decode_alu_if.slave carrying instruction fields, operands,
//          combinational decode outputs and registered res_q/zero_q/ctrl_q
// Decode outputs are combinational and independent of rst; the ALU result,
// zero flag and control bundle are registered (one cycle, hold freezes them).
// Macro ALU_OVERFLOW_DET_EN adds the registered signed-overflow flag ovf_q.
module mips_decode_alu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    mips_decode_alu_if.slave bus
);

    logic              regDst;
    logic              aluSrc;
    logic              memToReg;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              branch;
    aluOp_e            aluOp;
    aluCtl_e           aluCtl;
    logic [DATA_W-1:0] operandB;
    logic [DATA_W-1:0] aluResult;
    logic              aluZero;
    logic [CTRL_W-1:0] ctrlNext;

    // Main decoder: unknown opcodes decode to an all-zero bubble.
    always_comb begin
        regDst   = 1'b0;
        aluSrc   = 1'b0;
        memToReg = 1'b0;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        branch   = 1'b0;
        aluOp    = ALUOP_ADD;
        case (bus.opcode)
            OP_RTYPE: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                aluOp    = ALUOP_FUNCT;
            end
            OP_LW: begin
                aluSrc   = 1'b1;
                memToReg = 1'b1;
                regWrite = 1'b1;
                memRead  = 1'b1;
            end
            OP_SW: begin
                aluSrc   = 1'b1;
                memWrite = 1'b1;
            end
            OP_BEQ: begin
                branch   = 1'b1;
                aluOp    = ALUOP_SUB;
            end
            OP_ADDI: begin
                aluSrc   = 1'b1;
                regWrite = 1'b1;
            end
            OP_ORI: begin
                aluSrc   = 1'b1;
                regWrite = 1'b1;
                aluOp    = ALUOP_OR;
            end
            default: ;
        endcase
    end

    // ALU-control decoder
    always_comb begin
        aluCtl = ALU_INVALID;
        case (aluOp)
            ALUOP_ADD: aluCtl = ALU_ADD;
            ALUOP_SUB: aluCtl = ALU_SUB;
            ALUOP_OR:  aluCtl = ALU_OR;
            ALUOP_FUNCT: begin
                case (bus.funct)
                    FN_ADD:  aluCtl = ALU_ADD;
                    FN_SUB:  aluCtl = ALU_SUB;
                    FN_AND:  aluCtl = ALU_AND;
                    FN_OR:   aluCtl = ALU_OR;
                    FN_XOR:  aluCtl = ALU_XOR;
                    FN_NOR:  aluCtl = ALU_NOR;
                    FN_SLT:  aluCtl = ALU_SLT;
                    FN_SLL:  aluCtl = ALU_SLL;
                    FN_SRL:  aluCtl = ALU_SRL;
                    FN_SRA:  aluCtl = ALU_SRA;
                    default: aluCtl = ALU_INVALID;
                endcase
            end
            default: aluCtl = ALU_INVALID;
        endcase
    end

    assign bus.reg_dst    = regDst;
    assign bus.alu_src    = aluSrc;
    assign bus.mem_to_reg = memToReg;
    assign bus.reg_write  = regWrite;
    assign bus.mem_read   = memRead;
    assign bus.mem_write  = memWrite;
    assign bus.branch     = branch;
    assign bus.alu_op     = aluOp;
    assign bus.alu_ctl    = aluCtl;

    assign operandB = aluSrc ? bus.imm_ext : bus.rt_val;

    always_comb begin
        ctrlNext               = '0;
        ctrlNext[CB_REG_WRITE]  = regWrite;
        ctrlNext[CB_MEM_TO_REG] = memToReg;
        ctrlNext[CB_BRANCH]     = branch;
        ctrlNext[CB_MEM_READ]   = memRead;
        ctrlNext[CB_MEM_WRITE]  = memWrite;
    end

`ifdef ALU_OVERFLOW_DET_EN
    logic aluOvf;
`endif

    mips_alu_core #(.DATA_W(DATA_W)) u_core (
        .a      (bus.rs_val),
        .b      (operandB),
        .shamt  (bus.shamt),
        .ctl    (aluCtl),
        .result (aluResult),
        .zero   (aluZero)
`ifdef ALU_OVERFLOW_DET_EN
        ,
        .ovf    (aluOvf)
`endif
    );

    // Reset wins over hold; hold freezes every EX/MEM register together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.res_q  <= '0;
            bus.zero_q <= 1'b0;
            bus.ctrl_q <= '0;
        end else if (!bus.hold) begin
            bus.res_q  <= aluResult;
            bus.zero_q <= aluZero;
            bus.ctrl_q <= ctrlNext;
        end
    end

`ifdef ALU_OVERFLOW_DET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ovf_q <= 1'b0;
        end else if (!bus.hold) begin
            bus.ovf_q <= aluOvf;
        end
    end
`endif

endmodule

// File: tb/tb_mips_decode_alu.sv
// tb_mips_decode_alu: directed self-checking bench for mips_decode_alu.
// Drives instruction fields and operands through the interface, checks the
// combinational decode and the registered result/zero/control bundle one
// clock later. Define ALU_OVERFLOW_DET_EN to also check ovf_q.
module tb_mips_decode_alu;
    import mips_pkg::*;

    logic clk;
    logic rst;
    int   nCmp  = 0;
    int   nFail = 0;

    mips_decode_alu_if #(.DATA_W(32)) bus ();

    mips_decode_alu #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        bus.opcode  = op;
        bus.funct   = fn;
        bus.shamt   = sh;
        bus.rs_val  = a;
        bus.rt_val  = b;
        bus.imm_ext = im;
    endtask

    // Drive, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        drive(op, fn, sh, a, b, im);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] decVec();
        return {25'd0, bus.reg_dst, bus.branch, bus.mem_read, bus.mem_to_reg,
                bus.mem_write, bus.alu_src, bus.reg_write};
    endfunction

    initial begin
        rst      = 1'b0;
        bus.hold = 1'b0;
        drive(6'b0, 6'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("reset_res",  bus.res_q,  32'd0);
        check("reset_zero", {31'd0, bus.zero_q}, 32'd0);
        check("reset_ctrl", {27'd0, bus.ctrl_q}, 32'd0);
`ifdef ALU_OVERFLOW_DET_EN
        check("reset_ovf",  {31'd0, bus.ovf_q}, 32'd0);
`endif

        // Combinational decode while still in reset
        drive(6'b100011, 6'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        #1;
        // {reg_dst,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write}
        check("dec_lw_ctl",  decVec(), 32'b0011011);
        check("dec_lw_aop",  {30'd0, bus.alu_op}, 32'b00);
        check("dec_lw_actl", {28'd0, bus.alu_ctl}, 32'b0010);
        drive(6'b111111, 6'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        #1;
        check("dec_nop_ctl", decVec(), 32'd0);
        check("dec_nop_aop", {30'd0, bus.alu_op}, 32'd0);
        drive(6'b000000, 6'b111111, 5'd0, 32'd0, 32'd0, 32'd0);
        #1;
        check("dec_r_ctl",   decVec(), 32'b1000001);
        check("dec_inv_actl", {28'd0, bus.alu_ctl}, 32'b1111);

        @(negedge clk);
        rst = 1'b0;

        // R-type arithmetic
        step(6'b000000, 6'b100000, 5'd0, 32'd7, 32'd5, 32'd0);
        check("add_res",  bus.res_q, 32'd12);
        check("add_zero", {31'd0, bus.zero_q}, 32'd0);
        check("add_ctrl", {27'd0, bus.ctrl_q}, 32'b10000);
        step(6'b000000, 6'b100010, 5'd0, 32'd7, 32'd5, 32'd0);
        check("sub_res",  bus.res_q, 32'd2);
        step(6'b000000, 6'b100010, 5'd0, 32'd5, 32'd5, 32'd0);
        check("sub0_res",  bus.res_q, 32'd0);
        check("sub0_zero", {31'd0, bus.zero_q}, 32'd1);

        // SLT and shifts
        step(6'b000000, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check("slt_res", bus.res_q, 32'd1);
        step(6'b000000, 6'b101010, 5'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
        check("slt_rev", bus.res_q, 32'd0);
        step(6'b000000, 6'b000011, 5'd4, 32'd0, 32'h8000_0000, 32'd0);
        check("sra_res", bus.res_q, 32'hF800_0000);
        step(6'b000000, 6'b000010, 5'd4, 32'd0, 32'h8000_0000, 32'd0);
        check("srl_res", bus.res_q, 32'h0800_0000);
        step(6'b000000, 6'b000000, 5'd31, 32'd0, 32'd1, 32'd0);
        check("sll_res", bus.res_q, 32'h8000_0000);

        // Logic ops
        step(6'b000000, 6'b100100, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        check("and_res", bus.res_q, 32'hF000_F000);
        step(6'b000000, 6'b100101, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        check("or_res",  bus.res_q, 32'hFFF0_FFF0);
        step(6'b000000, 6'b100110, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        check("xor_res", bus.res_q, 32'h0FF0_0FF0);
        step(6'b000000, 6'b100111, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        check("nor_res", bus.res_q, 32'h000F_000F);

        // Invalid funct: result 0, zero asserted
        step(6'b000000, 6'b111111, 5'd0, 32'd9, 32'd9, 32'd0);
        check("inv_res",  bus.res_q, 32'd0);
        check("inv_zero", {31'd0, bus.zero_q}, 32'd1);

        // Immediate path and memory ops
        step(6'b001000, 6'b000000, 5'd0, 32'd10, 32'd99, 32'hFFFF_FFFE);
        check("addi_res",  bus.res_q, 32'd8);
        check("addi_ctrl", {27'd0, bus.ctrl_q}, 32'b10000);
        step(6'b001101, 6'b000000, 5'd0, 32'h0000_00F0, 32'd99, 32'h0000_000F);
        check("ori_res",   bus.res_q, 32'h0000_00FF);
        step(6'b000100, 6'b000000, 5'd0, 32'd3, 32'd3, 32'd100);
        check("beq_zero",  {31'd0, bus.zero_q}, 32'd1);
        check("beq_ctrl",  {27'd0, bus.ctrl_q}, 32'b00100);
        step(6'b100011, 6'b000000, 5'd0, 32'd100, 32'd7, 32'd4);
        check("lw_res",    bus.res_q, 32'd104);
        check("lw_ctrl",   {27'd0, bus.ctrl_q}, 32'b11010);
        step(6'b101011, 6'b000000, 5'd0, 32'd200, 32'd7, 32'd8);
        check("sw_res",    bus.res_q, 32'd208);
        check("sw_ctrl",   {27'd0, bus.ctrl_q}, 32'b00001);

        // hold keeps all registers
        bus.hold = 1'b1;
        step(6'b000000, 6'b100000, 5'd0, 32'd1, 32'd1, 32'd0);
        check("hold_res",  bus.res_q, 32'd208);
        check("hold_ctrl", {27'd0, bus.ctrl_q}, 32'b00001);
        bus.hold = 1'b0;
        step(6'b000000, 6'b100000, 5'd0, 32'd7, 32'd5, 32'd0);
        check("unhold_res", bus.res_q, 32'd12);

        // Async reset between edges, with hold also asserted
        bus.hold = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_res",  bus.res_q, 32'd0);
        check("arst_zero", {31'd0, bus.zero_q}, 32'd0);
        check("arst_ctrl", {27'd0, bus.ctrl_q}, 32'd0);
        #1 rst = 1'b0;
        bus.hold = 1'b0;
        step(6'b000000, 6'b100000, 5'd0, 32'd20, 32'd22, 32'd0);
        check("post_rst_res",  bus.res_q, 32'd42);
        check("post_rst_ctrl", {27'd0, bus.ctrl_q}, 32'b10000);

`ifdef ALU_OVERFLOW_DET_EN
        step(6'b000000, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0);
        check("ovf_add_res", bus.res_q, 32'h8000_0000);
        check("ovf_add",     {31'd0, bus.ovf_q}, 32'd1);
        step(6'b000000, 6'b100010, 5'd0, 32'h8000_0000, 32'd1, 32'd0);
        check("ovf_sub_res", bus.res_q, 32'h7FFF_FFFF);
        check("ovf_sub",     {31'd0, bus.ovf_q}, 32'd1);
        step(6'b000000, 6'b100000, 5'd0, 32'd3, 32'd4, 32'd0);
        check("ovf_none",    {31'd0, bus.ovf_q}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/mips_decode_alu.md
Name: mips_decode_alu

Overview:
- Combined main-control decoder, ALU-control decoder and 32-bit ALU for the 5-stage MIPS core; sits at the ID/EX boundary.
- The main decoder turns opcode into pipeline control signals, combinationally.
- The ALU-control decoder turns ALUOp plus funct into a 4-bit ALU operation. The ALU executes it on rs and on rt or the immediate.
- Result, zero flag and forwarded control bundle are registered: one-cycle latency into EX/MEM.

Parameters:
- DATA_W, 32, operand/result width; only 32 is required to work.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- hold  in  1  1 = output registers keep their value
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- shamt  in  5  instr[10:6]
- rs_val  in  32  operand A
- rt_val  in  32  register operand B
- imm_ext  in  32  sign-extended immediate
- reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  combinational decode of opcode
- alu_op  out  2  combinational ALUOp
- alu_ctl  out  4  combinational ALU operation code
- res_q  out  32  registered ALU result
- zero_q  out  1  registered (result == 0)
- ctrl_q  out  5  registered {reg_write, mem_to_reg, branch, mem_read, mem_write}

Behaviour:
- Main decode (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp):
  - R 000000: 1 0 0 1 0 0 0 10
  - lw 100011: 0 1 1 1 1 0 0 00
  - sw 101011: 0 1 0 0 0 1 0 00
  - beq 000100: 0 0 0 0 0 0 1 01
  - addi 001000: 0 1 0 1 0 0 0 00
  - ori 001101: 0 1 0 1 0 0 0 11
  - Any other opcode: all zero (NOP).
- Polarity: RegDst=1 selects rd; MemtoReg=1 selects memory data.
- ALU-control mapping:
  - ALUOp 00 -> ADD; 01 -> SUB; 11 -> OR; 10 -> decode funct.
  - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
  - funct 000000 SLL, 000010 SRL, 000011 SRA.
  - Other funct -> 1111 (invalid).
- ALU codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0101 XOR, 0110 SUB, 0111 SLT, 1100 NOR, 1101 SRA.
  - Any other code: result 0.
- Operand B = alu_src ? imm_ext : rt_val.
- ADD/SUB wrap modulo 2^32, no trap.
- SLT is signed: result 1 or 0.
- Shifts move operand B by shamt. SRA sign-fills.
- zero is asserted when the final 32-bit result is 0 (includes invalid-code result 0).
- Registers, on rising clk:
  - hold=0: capture result, zero and control bundle.
  - hold=1: keep all three.
- Reset:
  - rst asynchronously clears res_q=0, zero_q=0, ctrl_q=0 (bubble; no write or memory access).
  - rst has priority over hold.
  - Deasserting rst mid-operation: the first capture is on the next rising edge.
- Combinational outputs do not depend on rst.

Optional Feature:
- Macro ALU_OVERFLOW_DET_EN.
- Defined:
  - Extra output ovf_q (1 bit), registered like res_q and reset to 0.
  - Set on signed overflow of ADD (operands same sign, result sign differs) or SUB (operands differ in sign, result sign differs from A).
  - 0 for all other operations.
  - Result value is unchanged.
- Undefined: port and logic absent.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI);
  - funct constants;
  - ALUOp 2-bit enum;
  - ALU-control 4-bit enum including ALU_INVALID = 1111;
  - control-bundle bit positions.
- One sub-module, mips_alu_core: purely combinational (a, b, shamt, ctl) -> (result, zero, ovf).
- Both decoders stay as case statements in the top.

Test Plan:
- Decode sweep: opcode 100011 -> mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=00, alu_ctl=0010. Opcode 111111 -> all controls 0.
- R-type add/sub:
  - rs=7, rt=5, funct 100000 -> res_q=12 one cycle later.
  - funct 100010 -> res_q=2.
  - rs=5, rt=5, funct 100010 -> res_q=0, zero_q=1.
- SLT and shifts:
  - rs=0xFFFFFFFF, rt=1, funct 101010 -> res_q=1.
  - rt=0x80000000, shamt 4: SRA -> 0xF8000000; SRL -> 0x08000000; SLL with rt=1, shamt 31 -> 0x80000000.
- Immediate path:
  - addi with rs=10, imm_ext=0xFFFFFFFE -> res_q=8.
  - ori with rs=0xF0, imm=0x0F -> res_q=0xFF.
  - beq with rs=rt=3 -> zero_q=1, ctrl_q branch bit=1.
- hold/reset:
  - hold=1 keeps res_q across new inputs.
  - rst pulse between clock edges clears res_q, zero_q, ctrl_q immediately.
  - First edge after release captures the new result.
- With ALU_OVERFLOW_DET_EN:
  - 0x7FFFFFFF + 1 -> res_q=0x80000000, ovf_q=1.
  - 0x80000000 - 1 -> ovf_q=1.
  - 3 + 4 -> ovf_q=0.
